// File: rtl/avalon_ram_pkg.sv
// Shared types and constants for the Avalon-MM test RAM.
// The LFSR constants are only used when WAITREQ_LFSR_EN is defined.
package avalon_ram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_t;

    localparam int WORD_W = 32;
    localparam int LANES  = 4;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Taps for x^8+x^6+x^5+x^4+1, shifting towards the MSB.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/ram_wait_lfsr.sv
// Pseudo-random stall generator for avalon_test_ram.
// Instantiated only when WAITREQ_LFSR_EN is defined.
module ram_wait_lfsr
    import avalon_ram_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_step,
    output logic [3:0] o_count
);

    logic [7:0] r_lfsr;
    logic       w_feedback;

    assign w_feedback = ^(r_lfsr & LFSR_TAPS);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lfsr <= LFSR_SEED;
        end else if (i_step) begin
            r_lfsr <= {r_lfsr[6:0], w_feedback};
        end
    end

    assign o_count = 4'(32'(r_lfsr) % (WAIT_CYCLES + 1));

endmodule

// File: rtl/avalon_test_ram.sv
// Avalon-MM slave memory model with a configurable waitrequest stall.
// Define WAITREQ_LFSR_EN to replace the fixed stall with an LFSR-driven one.
module avalon_test_ram
    import avalon_ram_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h00000000,
    parameter int          WAIT_CYCLES = 2,
    parameter int          LOAD_AW     = $clog2(DEPTH_WORDS)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [31:0]        address,
    input  logic               write,
    input  logic               read,
    output logic               waitrequest,
    input  logic [31:0]        writedata,
    input  logic [3:0]         byteenable,
    output logic [31:0]        readdata,
    input  logic               load_en,
    input  logic [LOAD_AW-1:0] load_addr,
    input  logic [31:0]        load_data,
    input  logic               clear,
    output logic               err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

    state_t      r_state;
    state_t      w_stateNext;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cntNext;
    logic [3:0]  w_stall;
    logic [31:0] r_readdata;
    logic        r_err;
    logic        w_req;
    logic        w_capture;
    logic        w_legal;
    logic        w_commit;
    logic        w_accessErr;
    logic [29:0] w_wordOff;
    logic [AW-1:0] w_idx;

    assign w_req     = read | write;
    assign w_wordOff = address[31:2] - BASE_ADDR[31:2];
    assign w_idx     = w_wordOff[AW-1:0];
    assign w_legal   = (address[1:0] == 2'b00) && (w_wordOff[29:AW] == '0);

`ifdef WAITREQ_LFSR_EN
    ram_wait_lfsr #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .i_step  ((r_state == IDLE) && w_req),
        .o_count (w_stall)
    );
`else
    assign w_stall = 4'(WAIT_CYCLES);
`endif

    // The request cycle in IDLE is the first stalled cycle, so WAIT lasts
    // exactly w_stall cycles and a zero stall goes straight to ACK.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (w_stall == 4'd0) begin
                        w_cntNext   = 4'd0;
                        w_capture   = 1'b1;
                        w_stateNext = ACK;
                    end else begin
                        w_cntNext   = w_stall - 4'd1;
                        w_stateNext = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!w_req) begin
                    w_stateNext = IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_capture   = 1'b1;
                    w_stateNext = ACK;
                end else begin
                    w_cntNext = r_cnt - 4'd1;
                end
            end
            ACK:     w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    assign waitrequest = w_req && (r_state != ACK);
    assign w_commit    = (r_state == ACK) && write && !read && w_legal;
    assign w_accessErr = (r_state == ACK) && w_req && (!w_legal || (read && write));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_readdata <= 32'd0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            if (w_capture && read) begin
                r_readdata <= w_legal ? r_mem[w_idx] : 32'd0;
            end
            if (w_accessErr) begin
                r_err <= 1'b1;
            end
        end
    end

    // Memory survives reset; priority is clear, then preload, then bus write.
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_commit) begin
                for (int i = 0; i < LANES; i++) begin
                    if (byteenable[i]) begin
                        r_mem[w_idx][8*i +: 8] <= writedata[8*i +: 8];
                    end
                end
            end
            if (load_en) begin
                r_mem[load_addr] <= load_data;
            end
        end
    end

    assign readdata = r_readdata;
    assign err      = r_err;

endmodule

// File: tb/tb_avalon_test_ram.sv
// Scoreboard bench for avalon_test_ram: reads push expected data, a monitor
// pops and compares whenever a read completes (waitrequest low with read high).
module tb_avalon_test_ram;

    localparam int DEPTH = 16;
    localparam int WAITC = 3;
    localparam int LAW   = 4;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [31:0]    address = '0;
    logic           write = 1'b0;
    logic           read = 1'b0;
    logic           waitrequest;
    logic [31:0]    writedata = '0;
    logic [3:0]     byteenable = '0;
    logic [31:0]    readdata;
    logic           load_en = 1'b0;
    logic [LAW-1:0] load_addr = '0;
    logic [31:0]    load_data = '0;
    logic           clear = 1'b0;
    logic           err;

    logic [31:0] expQ [$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    avalon_test_ram #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (32'h00000000),
        .WAIT_CYCLES (WAITC),
        .LOAD_AW     (LAW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .address     (address),
        .write       (write),
        .read        (read),
        .waitrequest (waitrequest),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .readdata    (readdata),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .clear       (clear),
        .err         (err)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // One bus access; optionally fires a preload on the completing edge.
    task automatic applyStimulus(input string name, input logic doRead, input logic doWrite,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] be, input logic [31:0] expRead,
                                 input logic loadAtAck, input logic [31:0] loadWord);
        int stall = 0;
        bit done = 0;
        if (doRead) expQ.push_back(expRead);
        @(posedge clk);
        #1;
        address    = addr;
        read       = doRead;
        write      = doWrite;
        writedata  = wdata;
        byteenable = be;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (waitrequest) stall++;
            else done = 1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("[TB] FAIL %s timeout: waitrequest stuck high", name);
        end
        checkOutput({name, " stall"}, 32'(stall), 32'(WAITC + 1));
        if (loadAtAck) begin
            load_en   = 1'b1;
            load_addr = addr[LAW+1:2];
            load_data = loadWord;
        end
        @(posedge clk);
        #1;
        read    = 1'b0;
        write   = 1'b0;
        load_en = 1'b0;
    endtask

    task automatic preload(input logic [LAW-1:0] idx, input logic [31:0] data);
        @(posedge clk);
        #1;
        load_en   = 1'b1;
        load_addr = idx;
        load_data = data;
        @(posedge clk);
        #1;
        load_en = 1'b0;
    endtask

    task automatic resetPulse();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin : monitor
        logic [31:0] exp;
        forever begin
            @(negedge clk);
            if (reset_n && read && !waitrequest) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected read completion: readdata=%h", readdata);
                end else begin
                    exp = expQ.pop_front();
                    checkOutput("readdata", readdata, exp);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset readdata", readdata, 32'h0);
        checkOutput("reset err", 32'(err), 32'h0);
        checkOutput("reset waitrequest", 32'(waitrequest), 32'h0);
        reset_n = 1'b1;

        preload(4'd1, 32'h24030FF0);
        preload(4'd2, 32'h386200FF);
        applyStimulus("read w1", 1, 0, 32'h4, 0, 4'h0, 32'h24030FF0, 0, 0);
        applyStimulus("read w2", 1, 0, 32'h8, 0, 4'h0, 32'h386200FF, 0, 0);

        preload(4'd0, 32'h11223344);
        applyStimulus("write lanes", 0, 1, 32'h0, 32'hDEADBEEF, 4'b0101, 0, 0, 0);
        applyStimulus("read lanes", 1, 0, 32'h0, 0, 4'h0, 32'h11AD33EF, 0, 0);
        applyStimulus("write be0", 0, 1, 32'h0, 32'hFFFFFFFF, 4'b0000, 0, 0, 0);
        applyStimulus("read be0", 1, 0, 32'h0, 0, 4'h0, 32'h11AD33EF, 0, 0);
        @(negedge clk);
        checkOutput("err after legal", 32'(err), 32'h0);

        applyStimulus("read misaligned", 1, 0, 32'h6, 0, 4'h0, 32'h0, 0, 0);
        @(negedge clk);
        checkOutput("err misaligned", 32'(err), 32'h1);
        resetPulse();
        checkOutput("err cleared by reset", 32'(err), 32'h0);
        applyStimulus("read out of range", 1, 0, 32'h40, 0, 4'h0, 32'h0, 0, 0);
        @(negedge clk);
        checkOutput("err out of range", 32'(err), 32'h1);
        applyStimulus("write out of range", 0, 1, 32'h40, 32'hCAFEF00D, 4'hF, 0, 0, 0);
        applyStimulus("write misaligned", 0, 1, 32'h2, 32'hCAFEF00D, 4'hF, 0, 0, 0);
        applyStimulus("read w0 intact", 1, 0, 32'h0, 0, 4'h0, 32'h11AD33EF, 0, 0);

        resetPulse();
        applyStimulus("read+write", 1, 1, 32'h4, 32'h00000000, 4'hF, 32'h24030FF0, 0, 0);
        @(negedge clk);
        checkOutput("err read+write", 32'(err), 32'h1);
        applyStimulus("read w1 after rw", 1, 0, 32'h4, 0, 4'h0, 32'h24030FF0, 0, 0);

        // Abandoned read: readdata must keep the last completed read.
        @(posedge clk);
        #1;
        address = 32'h8;
        read    = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        read = 1'b0;
        @(negedge clk);
        checkOutput("dropped read readdata", readdata, 32'h24030FF0);
        checkOutput("dropped read waitrequest", 32'(waitrequest), 32'h0);

        // Reset in the middle of a write stall.
        @(posedge clk);
        #1;
        address    = 32'h4;
        writedata  = 32'h12345678;
        byteenable = 4'hF;
        write      = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("reset mid-write readdata", readdata, 32'h0);
        checkOutput("reset mid-write waitrequest", 32'(waitrequest), 32'h1);
        @(posedge clk);
        #1;
        write = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus("read w1 after reset", 1, 0, 32'h4, 0, 4'h0, 32'h24030FF0, 0, 0);

        preload(4'd3, 32'h00000000);
        applyStimulus("write vs load", 0, 1, 32'hC, 32'hAAAAAAAA, 4'hF, 0, 1, 32'h55AA55AA);
        applyStimulus("read load wins", 1, 0, 32'hC, 0, 4'h0, 32'h55AA55AA, 0, 0);

        @(posedge clk);
        #1;
        clear     = 1'b1;
        load_en   = 1'b1;
        load_addr = 4'd5;
        load_data = 32'hFFFF0000;
        @(posedge clk);
        #1;
        clear   = 1'b0;
        load_en = 1'b0;
        applyStimulus("read w0 cleared", 1, 0, 32'h0, 0, 4'h0, 32'h0, 0, 0);
        applyStimulus("read w1 cleared", 1, 0, 32'h4, 0, 4'h0, 32'h0, 0, 0);
        applyStimulus("read w3 cleared", 1, 0, 32'hC, 0, 4'h0, 32'h0, 0, 0);
        applyStimulus("read w5 clear>load", 1, 0, 32'h14, 0, 4'h0, 32'h0, 0, 0);

        repeat (4) @(negedge clk);
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
